// File: rtl/mux_pkg.sv
// Shared types for the scanning channel multiplexer.
// State encoding and mode constants.
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_nto1_scan_ptr.sv
// Dwell counter plus wrapping channel pointer.
// ptr/wrap give the channel to present on this edge.
module scan_ptr #(
  parameter int N_CH  = 8,
  parameter int DWELL = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    run,
  output logic [$clog2(N_CH)-1:0] ptr,
  output logic                    wrap
);

  localparam int SEL_W = $clog2(N_CH);
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [SEL_W-1:0] ptr_q, ptr_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  // next pointer/count: reload on entry, advance after a full dwell
  always_comb begin
    ptr_n = ptr_q;
    cnt_n = '0;
    wrap  = 1'b0;
    if (clr) begin
      ptr_n = '0;
    end else if (run) begin
      if (cnt_q == CNT_LAST) begin
        if (ptr_q == LAST) begin
          ptr_n = '0;
          wrap  = 1'b1;
        end else begin
          ptr_n = ptr_q + SEL_W'(1);
        end
      end else begin
        cnt_n = cnt_q + CNT_W'(1);
      end
    end
  end

  assign ptr = ptr_n;

  // pointer and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_n;
      cnt_q <= cnt_n;
    end
  end

endmodule

// File: rtl/mux_scan_nto1.sv
// Registered N-channel mux with manual select
// and timed auto-scan.
import mux_pkg::*;

module mux_scan_nto1 #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 1,
  parameter int SEL_W  = $clog2(N_CH),
  parameter int DWELL  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH*DATA_W-1:0] d,
  output logic [DATA_W-1:0]      y,
  output logic                   y_valid,
  output logic [SEL_W-1:0]       ch,
  output logic                   wrap
);

  state_t state, nxt;
  logic scan_clr, scan_run;
  logic [SEL_W-1:0] ptr;
  logic wrap_n;
  logic [DATA_W-1:0] man_y, scan_y;
  logic man_ok;

  // next state follows en/mode directly
  always_comb begin
    nxt = IDLE;
    if (en) nxt = (mode == MODE_SCAN) ? SCAN : MANUAL;
  end

  assign scan_run = (nxt == SCAN);
  assign scan_clr = scan_run && (state != SCAN);

  scan_ptr #(
    .N_CH (N_CH),
    .DWELL(DWELL)
  ) u_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (scan_clr),
    .run  (scan_run),
    .ptr  (ptr),
    .wrap (wrap_n)
  );

  // channel slices; out-of-range sel matches nothing
  always_comb begin
    man_y  = '0;
    man_ok = 1'b0;
    scan_y = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == SEL_W'(k)) begin
        man_y  = d[k*DATA_W +: DATA_W];
        man_ok = 1'b1;
      end
      if (ptr == SEL_W'(k)) scan_y = d[k*DATA_W +: DATA_W];
    end
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      y       <= '0;
      y_valid <= 1'b0;
      ch      <= '0;
      wrap    <= 1'b0;
    end else begin
      state <= nxt;
      unique case (nxt)
        MANUAL: begin
          ch      <= sel;
          y       <= man_ok ? man_y : '0;
          y_valid <= man_ok;
          wrap    <= 1'b0;
        end
        SCAN: begin
          ch      <= ptr;
          y       <= scan_y;
          y_valid <= 1'b1;
          wrap    <= wrap_n;
        end
        default: begin
          y       <= '0;
          y_valid <= 1'b0;
          wrap    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Scoreboard bench for mux_scan_nto1 over three
// configurations driven from shared stimulus.
module tb_mux_scan_nto1;

  typedef struct packed {
    logic [3:0] y;
    logic       v;
    logic [2:0] ch;
    logic       w;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en, mode;
  logic [2:0] sel;
  logic [1:0] sel_c;
  logic [19:0] dd;

  logic [0:0] y_a, y_c;
  logic [3:0] y_b;
  logic v_a, v_b, v_c, w_a, w_b, w_c;
  logic [2:0] ch_a, ch_b;
  logic [1:0] ch_c;

  always #5 clk = ~clk;

  assign sel_c = sel[1:0];

  mux_scan_nto1 #(.N_CH(8), .DATA_W(1), .DWELL(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .sel(sel), .d(dd[7:0]), .y(y_a), .y_valid(v_a),
    .ch(ch_a), .wrap(w_a));

  mux_scan_nto1 #(.N_CH(5), .DATA_W(4), .DWELL(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .sel(sel), .d(dd), .y(y_b), .y_valid(v_b),
    .ch(ch_b), .wrap(w_b));

  mux_scan_nto1 #(.N_CH(3), .DATA_W(1), .DWELL(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .sel(sel_c), .d(dd[2:0]), .y(y_c), .y_valid(v_c),
    .ch(ch_c), .wrap(w_c));

  int nch[3]  = '{8, 5, 3};
  int dw[3]   = '{1, 4, 1};
  int dwl[3]  = '{4, 4, 1};
  int selw[3] = '{3, 3, 2};

  bit in_scan[3];
  int step[3];
  int last_ch[3];

  exp_t q0[$], q1[$], q2[$];
  int checks = 0;
  int errors = 0;

  function automatic exp_t got(input int i);
    exp_t g;
    case (i)
      0: g = '{y: {3'b0, y_a}, v: v_a, ch: ch_a, w: w_a};
      1: g = '{y: y_b, v: v_b, ch: ch_b, w: w_b};
      default: g = '{y: {3'b0, y_c}, v: v_c, ch: {1'b0, ch_c}, w: w_c};
    endcase
    return g;
  endfunction

  task automatic cmp(input string nm, input int i, input exp_t g, input exp_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t: got y=%h v=%b ch=%0d wrap=%b, want y=%h v=%b ch=%0d wrap=%b",
               nm, i, $time, g.y, g.v, g.ch, g.w, e.y, e.v, e.ch, e.w);
    end
  endtask

  // reference: scan position is a step count since scan entry
  task automatic model(input int i, input bit e, input bit m,
                       input logic [2:0] s, input logic [19:0] x,
                       output exp_t r);
    int ss, c, msk;
    r = '0;
    msk = (1 << dw[i]) - 1;
    ss = int'(s) & ((1 << selw[i]) - 1);
    if (!e) begin
      r.ch = 3'(last_ch[i]);
      in_scan[i] = 0;
    end else if (!m) begin
      r.ch = 3'(ss);
      if (ss < nch[i]) begin
        r.y = 4'((int'(x) >> (ss * dw[i])) & msk);
        r.v = 1'b1;
      end
      in_scan[i] = 0;
      last_ch[i] = ss;
    end else begin
      if (!in_scan[i]) step[i] = 0;
      else step[i]++;
      c = (step[i] / dwl[i]) % nch[i];
      r.ch = 3'(c);
      r.y = 4'((int'(x) >> (c * dw[i])) & msk);
      r.v = 1'b1;
      r.w = (step[i] > 0) && (step[i] % (dwl[i] * nch[i]) == 0);
      in_scan[i] = 1;
      last_ch[i] = c;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      in_scan[i] = 0;
      step[i] = 0;
      last_ch[i] = 0;
    end
  endtask

  task automatic drive(input bit e, input bit m,
                       input logic [2:0] s, input logic [19:0] x);
    exp_t r;
    @(posedge clk);
    #2;
    en = e; mode = m; sel = s; dd = x;
    model(0, e, m, s, x, r); q0.push_back(r);
    model(1, e, m, s, x, r); q1.push_back(r);
    model(2, e, m, s, x, r); q2.push_back(r);
  endtask

  task automatic check_zero(input string nm);
    for (int i = 0; i < 3; i++) cmp(nm, i, got(i), '0);
  endtask

  // monitor: one expectation per instance per edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin e = q0.pop_front(); cmp("out", 0, got(0), e); end
      if (q1.size() > 0) begin e = q1.pop_front(); cmp("out", 1, got(1), e); end
      if (q2.size() > 0) begin e = q2.pop_front(); cmp("out", 2, got(2), e); end
    end
  end

  initial begin
    bit m;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = '0; dd = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    #1 rst_n = 1'b1;

    // disabled with all-ones data
    repeat (3) drive(0, 0, 3'($urandom), 20'hFFFFF);

    // manual sweep over every select value
    for (int s = 0; s < 8; s++) drive(1, 0, 3'(s), 20'h5C3A6);

    // long scan with changing data
    for (int k = 0; k < 40; k++) drive(1, 1, 3'($urandom), 20'($urandom));

    // fresh scan, break to manual mid-dwell, back, enable drop
    drive(0, 1, 0, 0);
    for (int k = 0; k < 22; k++) drive(1, 1, 0, 20'($urandom));
    drive(1, 0, 3'd3, 20'($urandom));
    for (int k = 0; k < 10; k++) drive(1, 1, 0, 20'($urandom));
    repeat (2) drive(0, 1, 0, 20'hFFFFF);
    for (int k = 0; k < 10; k++) drive(1, 1, 0, 20'($urandom));

    // random mode/enable mix
    m = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(9) == 0) m = !m;
      drive($urandom_range(15) != 0, m, 3'($urandom), 20'($urandom));
    end

    // asynchronous reset mid-scan
    for (int k = 0; k < 7; k++) drive(1, 1, 0, 20'($urandom));
    #3;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    check_zero("async_reset");
    q0.delete(); q1.delete(); q2.delete();
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 20; k++) drive(1, 1, 0, 20'($urandom));
    drive(1, 0, 3'd4, 20'hABCDE);

    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0",
               q0.size() + q1.size() + q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_nto1.md
Name: mux_scan_nto1

Overview:
- Parametrised, registered N-channel, W-bit multiplexer with an enable input.
- Two modes:
  - manual select: select comes from a port.
  - auto-scan: an internal pointer steps through the channels, holding each one for a programmable number of cycles.
- Sits between the channel sources and the downstream display/counter logic. Replaces the fixed 8:1 single-bit combinational mux where time-multiplexed channel access is needed.

Parameters:
- N_CH, 8, number of input channels (2..256, need not be a power of 2).
- DATA_W, 1, width of each channel in bits.
- SEL_W, $clog2(N_CH), width of the select and pointer fields (derived; do not override).
- DWELL, 4, cycles each channel is held in scan mode (1..65535).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  block enable; low forces the output to zero.
- mode  in  1  0 = manual select, 1 = auto-scan.
- sel  in  SEL_W  channel select, used in manual mode only.
- d  in  N_CH*DATA_W  packed channel inputs; channel k occupies d[k*DATA_W +: DATA_W].
- y  out  DATA_W  registered selected data.
- y_valid  out  1  y holds a legal channel's data.
- ch  out  SEL_W  channel index currently presented on y.
- wrap  out  1  one-cycle pulse when the scan pointer wraps from N_CH-1 to 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - y=0, y_valid=0, ch=0, wrap=0.
  - State=IDLE, scan pointer=0, dwell counter=0.
- All outputs are registered. Latency is 1 cycle: inputs sampled at edge t appear on the outputs after edge t.
- State machine (evaluated every edge):
  - IDLE: entered while en=0.
    - y=0, y_valid=0, wrap=0, dwell counter cleared.
    - ch and the scan pointer hold their values.
  - MANUAL: en=1, mode=0.
    - ch<=sel.
    - If sel<N_CH: y<=channel sel, y_valid<=1.
    - If sel>=N_CH (non-power-of-2 N_CH): y<=0, y_valid<=0.
    - wrap=0; dwell counter held at 0.
  - SCAN: en=1, mode=1.
    - y<=channel[pointer], ch<=pointer, y_valid<=1.
    - Dwell counter counts 0..DWELL-1.
    - When the counter reaches DWELL-1: the counter returns to 0 and the pointer advances.
    - If the pointer was N_CH-1, it wraps to 0 and wrap pulses with that same edge.
- Transitions:
  - Any state -> IDLE when en=0.
  - IDLE -> MANUAL or SCAN per mode when en=1.
  - MANUAL <-> SCAN per mode.
- Entering SCAN from MANUAL or IDLE: the pointer reloads to 0 and the dwell counter to 0. The first scanned channel is always 0 and is held for a full DWELL cycles.
- SCAN -> MANUAL: the next output is channel sel. No partial dwell state is carried over.
- DWELL=1: the pointer advances every cycle.
- Input data is re-sampled every cycle, so a channel's value changing during its dwell is tracked, not frozen.
- en dropped mid-dwell: the output zeroes on the next edge. On re-enable in SCAN, the scan restarts at channel 0.
- Reset asserted mid-scan: all state clears immediately, without waiting for clk.
- wrap is never asserted outside SCAN.

Decomposition:
- Shared package (mux_pkg) holds:
  - the state encoding: IDLE=2'd0, MANUAL=2'd1, SCAN=2'd2;
  - the mode constants MODE_MANUAL=1'b0, MODE_SCAN=1'b1.
- One sub-module, scan_ptr: the dwell counter plus wrapping channel pointer.
  - Parameters: N_CH, DWELL.
  - Ports: clk, rst_n, clr, run; outputs ptr and wrap.
- Data path (channel slice plus output registers) and FSM stay in the top module.

Test Plan:
- Reset/enable:
  - Assert rst_n=0 mid-run -> all outputs 0 immediately, with no clock edge.
  - en=0 with d=8'hFF -> y=0, y_valid=0.
- Manual sweep (N_CH=8, DATA_W=1), d=8'b1010_0110, en=1, mode=0, sel=0..7 one per cycle -> y=0,1,1,0,0,1,0,1 each one cycle later; ch tracks sel; y_valid=1.
- Non-power-of-2 (N_CH=5, DATA_W=4), sel=5,6,7 -> y=0, y_valid=0; sel=4 -> y=channel 4 data, y_valid=1.
- Auto-scan (N_CH=8, DWELL=4), mode=1 for 40 cycles:
  - ch sequence 0,0,0,0,1,1,1,1,...,7,7,7,7,0.
  - wrap high exactly on the cycle ch returns to 0.
  - y matches d[ch] every cycle.
- Mode/enable interruption (N_CH=8, DWELL=4):
  - Switch to manual with sel=3 at ch=5 mid-dwell -> ch=3 next cycle, wrap stays 0.
  - Return to scan -> restarts at ch=0 with a full 4-cycle dwell.
  - en dropped for 2 cycles mid-scan -> outputs zero; on re-enable, scan restarts at channel 0.
- DWELL=1, N_CH=3 -> ch=0,1,2,0,1,2; wrap pulses every 3rd cycle.
